vga_scan_driver: RTL and testbench

- Raster timing generator and DAC output stage for the 640x480@60 display.
- Produces the `xpixel`/`ypixel`/`blank` scan coordinates consumed by the top-level drawing compositor.
- Samples the compositor's registered 24-bit rgb and drives the ADV7123-style VGA pins.
- Delays hsync/vsync/blank to match the compositor pipeline, and emits a once-per-frame tick for game logic.

---
 rtl/vga_timing_pkg.sv | 34 +++
 rtl/sync_delay_line.sv | 34 +++
 rtl/vga_scan_driver.sv | 141 ++++++++++++++
 tb/tb_vga_scan_driver.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared raster timing for the 640x480@60 VGA output path: default timing
// constants, derived sync windows, the coordinate type and the sync bundle.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Inclusive count ranges during which the raw syncs are asserted.
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic [23:0] RGB_BLACK = 24'h000000;

    // Timing bits that travel together down the alignment delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_bus_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a synchronous flush to a known value; used
// to delay raw hsync/vsync/blank so they line up with the colour pipeline.
module sync_delay_line #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clk; reset refills every stage with the flush value.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this small array is reset on purpose because its contents reach the
            // pins directly; bulk storage (RAMs) is normally left unreset.
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= FLUSH_VAL;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster generator and DAC output stage: pixel divider, h/v counters,
// sync decode, pipeline-matched sync/blank delay and registered DAC pins.
module vga_scan_driver #(
    parameter int   H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP        = vga_timing_pkg::H_FP,
    parameter int   H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int   H_BP        = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP        = vga_timing_pkg::V_FP,
    parameter int   V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int   V_BP        = vga_timing_pkg::V_BP,
    parameter int   CLK_DIV     = 2,
    parameter int   PIPE_LAT    = 1,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] rgb_in,
    output logic [9:0]  xpixel,
    output logic [9:0]  ypixel,
    output logic        blank,
    output logic        pix_en,
    output logic        frame_tick,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        vga_clk
);

    import vga_timing_pkg::*;

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    typedef logic [DIV_W-1:0] div_t;

    localparam div_t   DIV_LAST = div_t'(CLK_DIV - 1);
    localparam div_t   DIV_HALF = div_t'(CLK_DIV / 2);
    localparam coord_t H_LAST   = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);
    localparam coord_t V_TICK   = coord_t'(V_ACTIVE - 1);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam sync_bus_t BUS_FLUSH = '{hs: 1'b0, vs: 1'b0, blank: 1'b1};

    div_t        div_q, div_d;
    coord_t      hcount_q, hcount_d;
    coord_t      vcount_q, vcount_d;
    logic        vga_clk_q;
    logic        hs_raw, vs_raw;
    sync_bus_t   raw_bus, dly_bus;
    logic [23:0] rgb_q;
    logic        blank_n_q, hs_q, vs_q;

    assign pix_en     = (div_q == DIV_LAST);
    assign frame_tick = pix_en && (hcount_q == H_LAST) && (vcount_q == V_TICK);

    // Next state of the pixel divider and the raster counters.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        div_d    = div_q + div_t'(1);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pix_en) begin
            div_d = '0;
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + coord_t'(1);
            end else begin
                hcount_d = hcount_q + coord_t'(1);
            end
        end
    end

    // Counter flops; vga_clk is decoded from the next divider value so it is itself a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q     <= '0;
            hcount_q  <= '0;
            vcount_q  <= '0;
            vga_clk_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            div_q     <= div_d;
            hcount_q  <= hcount_d;
            vcount_q  <= vcount_d;
            vga_clk_q <= (div_d >= DIV_HALF);
        end
    end

    assign xpixel  = hcount_q;
    assign ypixel  = vcount_q;
    assign vga_clk = vga_clk_q;

    assign blank   = (hcount_q >= H_VIS) || (vcount_q >= V_VIS);
    assign hs_raw  = (hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST);
    assign vs_raw  = (vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST);
    assign raw_bus = '{hs: hs_raw, vs: vs_raw, blank: blank};

    // The compositor needs PIPE_LAT clks to produce rgb_in; the output register
    // below is the final stage, so the syncs see PIPE_LAT+1 clks in total.
    sync_delay_line #(
        .DEPTH     (PIPE_LAT),
        .WIDTH     ($bits(sync_bus_t)),
        .FLUSH_VAL (BUS_FLUSH)
    ) u_sync_delay (
        .clk    (clk),
        .reset  (reset),
        .data_i (raw_bus),
        .data_o (dly_bus)
    );

    // DAC output register: colour forced black while the aligned blank is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q     <= RGB_BLACK;
            blank_n_q <= 1'b0;
            hs_q      <= ~SYNC_ACTIVE;
            vs_q      <= ~SYNC_ACTIVE;
        end else begin
            rgb_q     <= dly_bus.blank ? RGB_BLACK : rgb_in;
            blank_n_q <= ~dly_bus.blank;
            hs_q      <= dly_bus.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs_q      <= dly_bus.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    assign {vga_r, vga_g, vga_b} = rgb_q;
    assign vga_blank_n           = blank_n_q;
    assign vga_hs                = hs_q;
    assign vga_vs                = vs_q;
    assign vga_sync_n            = 1'b0;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver. A reduced-raster instance is compared every clk
// against a time-based arithmetic model under pattern, random and white
// colour input with random resets; a default 640x480 instance is checked for
// the real hsync timing and the colour alignment on line 7.
module tb_vga_scan_driver;

    // Reduced raster so whole frames fit in a short run.
    localparam int S_HA  = 24, S_HFP = 3, S_HS = 5, S_HBP = 4;
    localparam int S_VA  = 8,  S_VFP = 2, S_VS = 2, S_VBP = 3;
    localparam int S_HT  = S_HA + S_HFP + S_HS + S_HBP;
    localparam int S_VT  = S_VA + S_VFP + S_VS + S_VBP;
    localparam int DIV   = 2;
    localparam int DEF_CYCLES = 14500;

    typedef enum {M_PATTERN, M_RANDOM, M_WHITE} mode_e;

    bit clk;
    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reduced-raster instance ----------------
    logic        rst_s;
    logic [23:0] rgb_s;
    logic [9:0]  xs, ys;
    logic        blank_s, pix_en_s, ft_s, hs_s, vs_s, bn_s, sn_s, vclk_s;
    logic [7:0]  r_s, g_s, b_s;

    vga_scan_driver #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .CLK_DIV(DIV), .PIPE_LAT(1), .SYNC_ACTIVE(1'b0)
    ) dut_small (
        .clk(clk), .reset(rst_s), .rgb_in(rgb_s),
        .xpixel(xs), .ypixel(ys), .blank(blank_s), .pix_en(pix_en_s),
        .frame_tick(ft_s), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s),
        .vga_hs(hs_s), .vga_vs(vs_s), .vga_blank_n(bn_s),
        .vga_sync_n(sn_s), .vga_clk(vclk_s)
    );

    // ---------------- default-raster instance ----------------
    logic        rst_b;
    logic [23:0] rgb_b;
    logic [9:0]  xb, yb;
    logic        blank_b, pix_en_b, ft_b, hs_b, vs_b, bn_b, sn_b, vclk_b;
    logic [7:0]  r_b, g_b, b_b;
    bit          done_b = 1'b0;

    vga_scan_driver dut_default (
        .clk(clk), .reset(rst_b), .rgb_in(rgb_b),
        .xpixel(xb), .ypixel(yb), .blank(blank_b), .pix_en(pix_en_b),
        .frame_tick(ft_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(bn_b),
        .vga_sync_n(sn_b), .vga_clk(vclk_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_blank(input int h, input int v);
        return (h >= S_HA) || (v >= S_VA);
    endfunction

    function automatic bit ref_hs(input int h);
        return (h >= S_HA + S_HFP) && (h < S_HA + S_HFP + S_HS);
    endfunction

    function automatic bit ref_vs(input int v);
        return (v >= S_VA + S_VFP) && (v < S_VA + S_VFP + S_VS);
    endfunction

    int    n;          // clk edges since the last edge that sampled reset
    int    ticks;
    mode_e mode;
    logic [23:0] comp_q;

    // Compare every small-instance output with what n clks after reset implies.
    task automatic check_small();
        int  p, div, h, v, q, hq, vq;
        bit  eb, ehs, evs;
        p   = n / DIV;
        div = n % DIV;
        h   = p % S_HT;
        v   = (p / S_HT) % S_VT;
        check("xpixel", xs, h);
        check("ypixel", ys, v);
        check("blank", blank_s, ref_blank(h, v));
        check("pix_en", pix_en_s, div == DIV - 1);
        check("frame_tick", ft_s, (div == DIV - 1) && (h == S_HT - 1) && (v == S_VA - 1));
        check("vga_clk", vclk_s, div >= DIV / 2);
        check("vga_sync_n", sn_s, 0);
        // Pins show the raster state from two clks earlier; before that, the flush values.
        if (n < 2) begin
            eb = 1'b1; ehs = 1'b0; evs = 1'b0;
        end else begin
            q   = (n - 2) / DIV;
            hq  = q % S_HT;
            vq  = (q / S_HT) % S_VT;
            eb  = ref_blank(hq, vq);
            ehs = ref_hs(hq);
            evs = ref_vs(vq);
        end
        check("vga_blank_n", bn_s, !eb);
        check("vga_hs", hs_s, ehs ? 1'b0 : 1'b1);
        check("vga_vs", vs_s, evs ? 1'b0 : 1'b1);
        check("colour", {r_s, g_s, b_s}, eb ? 24'h0 : rgb_s);
        if (ft_s === 1'b1) ticks++;
    endtask

    // One clk: apply reset choice, check after the edge, then drive next rgb_in.
    task automatic step(input bit rst_now);
        rst_s = rst_now;
        @(negedge clk);
        if (rst_now) n = 0;
        else         n = n + 1;
        check_small();
        case (mode)
            M_PATTERN: begin
                rgb_s  = comp_q;
                comp_q = {xs[7:0], ys[7:0], 8'hA5};
            end
            M_RANDOM: rgb_s = 24'($urandom);
            default:  rgb_s = 24'hFFFFFF;
        endcase
    endtask

    // Main sequence on the reduced raster.
    initial begin : small_raster
        bit found;
        rgb_s  = '0;
        comp_q = '0;
        mode   = M_PATTERN;
        n      = 0;
        ticks  = 0;
        repeat (3) step(1'b1);

        // Three uninterrupted frames: exactly three frame ticks.
        ticks = 0;
        for (int i = 0; i < 3 * S_HT * S_VT * DIV; i++) step(1'b0);
        check("frame_tick_count", ticks, 3);

        // Random colour with random resets landing anywhere in the frame.
        mode = M_RANDOM;
        for (int i = 0; i < 2000; i++) step($urandom_range(0, 149) == 0);

        // Reset mid-line, mid-frame at (15,5).
        found = 1'b0;
        for (int i = 0; i < 2 * S_HT * S_VT * DIV; i++) begin
            if (xs == 10'd15 && ys == 10'd5) begin
                found = 1'b1;
                break;
            end
            step(1'b0);
        end
        check("reach_15_5", found, 1);
        step(1'b1);
        for (int i = 0; i < 300; i++) step(1'b0);

        // White input: every blanked clk must still show black.
        mode = M_WHITE;
        for (int i = 0; i < S_HT * S_VT * DIV + 40; i++) step(1'b0);

        found = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (done_b) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("default_raster_done", found, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Default 640x480 instance: hsync timing and line-7 colour alignment.
    initial begin : default_raster
        int          hs_fall_1, hs_fall_2, hs_low, rises, falls, sync_bad;
        logic        prev_hs, prev_bn;
        logic [23:0] comp_b, prev_rgb;
        hs_fall_1 = -1; hs_fall_2 = -1; hs_low = 0;
        rises = 0; falls = 0; sync_bad = 0;
        rst_b = 1'b1; rgb_b = '0; comp_b = '0;
        @(negedge clk);
        rst_b    = 1'b0;
        prev_hs  = hs_b;
        prev_bn  = bn_b;
        prev_rgb = {r_b, g_b, b_b};
        check("def_reset_x", xb, 0);
        check("def_reset_blank_n", bn_b, 0);
        for (int k = 1; k <= DEF_CYCLES; k++) begin
            @(negedge clk);
            if (prev_hs === 1'b1 && hs_b === 1'b0) begin
                if (hs_fall_1 < 0)      hs_fall_1 = k;
                else if (hs_fall_2 < 0) hs_fall_2 = k;
            end
            if (hs_fall_1 >= 0 && hs_fall_2 < 0 && hs_b === 1'b0) hs_low++;
            if (prev_bn === 1'b0 && bn_b === 1'b1) begin
                rises++;
                if (rises == 8) check("line7_first_rgb", {r_b, g_b, b_b}, 24'h0007A5);
            end
            if (prev_bn === 1'b1 && bn_b === 1'b0) begin
                falls++;
                if (falls == 8) begin
                    check("line7_last_r", prev_rgb[23:16], 8'h7F);
                    check("line7_after_last", {r_b, g_b, b_b}, 24'h0);
                end
            end
            if (sn_b !== 1'b0) sync_bad++;
            prev_hs  = hs_b;
            prev_bn  = bn_b;
            prev_rgb = {r_b, g_b, b_b};
            rgb_b    = comp_b;
            comp_b   = {xb[7:0], yb[7:0], 8'hA5};
        end
        check("first_hs_fall", hs_fall_1, 656 * 2 + 2);
        check("hs_period", hs_fall_2 - hs_fall_1, 1600);
        check("hs_low_width", hs_low, 192);
        check("line7_seen", rises >= 8 && falls >= 8, 1);
        check("def_sync_n_high_clks", sync_bad, 0);
        done_b = 1'b1;
    end

endmodule
